cf_weight_apply: RTL and testbench

Consumer of the 8-bit coherence-factor stream produced by the 8-channel coherence path.
- Delays the beamformed (summed) echo sample stream so each sample lines up with its coherence coefficient.
- Multiplies each sample by the coefficient (Q0.8 weight), rounds, and emits the weighted sample.
- Frames output per scan line, with a sample counter and line-done strobe; feeds the envelope/log-compression stage.

---
 rtl/cf_weight_apply.sv | 133 +++++++++++++
 tb/tb_cf_weight_apply.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cf_weight_apply.sv
// cf_weight_apply: aligns each beamformed sample with its coherence factor, weights it (coff/256, round half up) and frames scan lines; latency DELAY+2.
// No backpressure: din is accepted whenever a line is open; CF_POWER_EN squares the coefficient first (latency DELAY+3).
module cf_weight_apply #(
  parameter int DATA_W   = 16,
  parameter int COFF_W   = 8,
  parameter int DELAY    = 24,
  parameter int LINE_LEN = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     line_start,
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din,
  input  logic        [COFF_W-1:0] coff,
  output logic                     dout_valid,
  output logic signed [DATA_W-1:0] dout,
  output logic                     line_done,
  output logic                     busy,
  output logic                     abort
);

`ifdef CF_POWER_EN
  localparam int DL = DELAY + 1;
`else
  localparam int DL = DELAY;
`endif
  localparam int CNT_W  = $clog2(LINE_LEN + 1);
  localparam int PROD_W = DATA_W + COFF_W + 1;
  localparam logic [CNT_W-1:0]         LAST = CNT_W'(LINE_LEN - 1);
  localparam logic signed [PROD_W-1:0] HALF = PROD_W'(2 ** (COFF_W - 1));

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]                     state_q, state_d;
  logic                           busy_q;
  logic [CNT_W-1:0]               in_cnt_q, in_cnt_d, in_base;
  logic [CNT_W-1:0]               out_cnt_q, out_cnt_d;
  logic [DL-1:0]                  vld_q, vld_d, vld_keep;
  logic [DL-1:0][DATA_W-1:0]      dat_q, dat_d;
  logic                           p_vld_q, p_vld_d;
  logic signed [PROD_W-1:0]       prod_q, prod_d, rnd;
  logic                           dvld_q, dvld_d;
  logic signed [DATA_W-1:0]       dout_q, dout_d, samp;
  logic                           ld_q, ld_d;
  logic                           accept;
  logic [COFF_W-1:0]              wt;
  logic signed [COFF_W:0]         wt_s;

`ifdef CF_POWER_EN
  // CF^2 weight, registered; the extra delay-line stage keeps the pairing.
  logic [COFF_W-1:0]   w_q, w_d;
  logic [2*COFF_W:0]   sq_rnd;

  always_comb begin
    sq_rnd = (2*COFF_W+1)'(coff) * (2*COFF_W+1)'(coff) + (2*COFF_W+1)'(2 ** (COFF_W - 1));
    w_d    = COFF_W'(sq_rnd >> COFF_W);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_q <= '0;
    else      w_q <= w_d;
  end

  assign wt = w_q;
`else
  assign wt = coff;
`endif

  always_comb begin
    accept   = din_valid && (line_start || state_q == S_RUN);
    in_base  = line_start ? '0 : in_cnt_q;
    in_cnt_d = accept ? in_base + CNT_W'(1) : in_base;

    state_d = state_q;
    if (line_start)                         state_d = S_RUN;
    else if (state_q == S_DRAIN && ld_q)    state_d = S_IDLE;
    if (accept && in_base == LAST)          state_d = S_DRAIN;

    // A new line flushes everything in flight; only its own first sample enters.
    vld_keep = line_start ? '0 : vld_q;
    vld_d    = DL'({vld_keep, accept});
    dat_d    = (DL*DATA_W)'({dat_q, din});

    samp    = dat_q[DL-1];
    wt_s    = {1'b0, wt};
    p_vld_d = vld_q[DL-1] && !line_start;
    prod_d  = PROD_W'(samp) * PROD_W'(wt_s);

    rnd       = prod_q + HALF;
    dvld_d    = p_vld_q && !line_start;
    dout_d    = dvld_d ? DATA_W'(rnd >>> COFF_W) : dout_q;
    ld_d      = dvld_d && out_cnt_q == LAST;
    out_cnt_d = line_start ? '0 : (p_vld_q ? out_cnt_q + CNT_W'(1) : out_cnt_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
      dat_q     <= '0;
      p_vld_q   <= 1'b0;
      prod_q    <= '0;
      dvld_q    <= 1'b0;
      dout_q    <= '0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      vld_q     <= vld_d;
      dat_q     <= dat_d;
      p_vld_q   <= p_vld_d;
      prod_q    <= prod_d;
      dvld_q    <= dvld_d;
      dout_q    <= dout_d;
      ld_q      <= ld_d;
    end
  end

  // A restart coinciding with the final output completes the old line instead of aborting it.
  assign abort      = line_start && (state_q != S_IDLE) && !ld_q;
  assign dout_valid = dvld_q;
  assign dout       = dout_q;
  assign line_done  = ld_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_cf_weight_apply.sv
// Bench for cf_weight_apply: directed steps plus random traffic, checked every cycle against a sample-level line/latency model.
module tb_cf_weight_apply;
  localparam int DATA_W   = 16;
  localparam int COFF_W   = 8;
  localparam int DELAY    = 24;
  localparam int LINE_LEN = 16;
`ifdef CF_POWER_EN
  localparam int LAT = DELAY + 3;
  localparam int FX0 = 250, FX1 = -992, FX2 = 32511, FX3 = 0;
`else
  localparam int LAT = DELAY + 2;
  localparam int FX0 = 500, FX1 = -996, FX2 = 32639, FX3 = 0;
`endif

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     line_start;
  logic                     din_valid;
  logic signed [DATA_W-1:0] din;
  logic        [COFF_W-1:0] coff;
  logic                     dout_valid;
  logic signed [DATA_W-1:0] dout;
  logic                     line_done;
  logic                     busy;
  logic                     abort;

  cf_weight_apply #(.DATA_W(DATA_W), .COFF_W(COFF_W), .DELAY(DELAY), .LINE_LEN(LINE_LEN)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .din_valid(din_valid), .din(din), .coff(coff),
    .dout_valid(dout_valid), .dout(dout), .line_done(line_done), .busy(busy), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int acc; int d; bit last; } exp_t;

  exp_t pend[$];
  int   coff_hist[int];
  int   coff_plan[int];
  int   fixed_exp[int];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   busy_m = 0;
  int   acc_cnt = LINE_LEN;
  int   held = 0;
  int   k0;
  int   last_acc;

  function automatic int weight(input int c);
`ifdef CF_POWER_EN
    return (c * c + 128) / 256;
`else
    return c;
`endif
  endfunction

  // floor((d*w + 128) / 256)
  function automatic int expect_val(input int d, input int w);
    int num;
    num = d * w + 128;
    if (num >= 0) return num / 256;
    return -((-num + 255) / 256);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit ls, input bit dv, input int d);
    int   c;
    bit   e_vld, e_ld, e_ab;
    exp_t e;
    c = coff_plan.exists(cyc) ? coff_plan[cyc] : int'($urandom_range(0, 255));
    line_start = ls;
    din_valid  = dv;
    din        = d[DATA_W-1:0];
    coff       = c[COFF_W-1:0];
    coff_hist[cyc] = c;
    e_vld = 0;
    e_ld  = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e     = pend.pop_front();
      e_vld = 1;
      e_ld  = e.last;
      held  = expect_val(e.d, weight(coff_hist[e.acc + DELAY]));
    end
    e_ab = ls && busy_m && !e_ld;
    #1;
    chk("dout_valid", dout_valid, e_vld);
    chk("dout", dout, held);
    chk("line_done", line_done, e_ld);
    chk("busy", busy, busy_m);
    chk("abort", abort, e_ab);
    if (fixed_exp.exists(cyc)) begin
      chk("directed_vld", dout_valid, 1);
      chk("directed_dout", dout, fixed_exp[cyc]);
    end
    if (ls) begin
      pend.delete();
      acc_cnt = 0;
    end
    if (dv && (ls || busy_m) && acc_cnt < LINE_LEN) begin
      e.due  = cyc + LAT;
      e.acc  = cyc;
      e.d    = int'(din);
      e.last = (acc_cnt == LINE_LEN - 1);
      pend.push_back(e);
      acc_cnt++;
    end
    busy_m = ls ? 1'b1 : (e_ld ? 1'b0 : busy_m);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int rnd_din();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  initial begin
    rst = 1'b0; line_start = 1'b0; din_valid = 1'b0; din = '0; coff = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // Single samples with fixed coefficients, then completing the line plus one ignored extra sample.
    k0 = cyc;
    coff_plan[k0 + DELAY]     = 128; fixed_exp[k0 + LAT]     = FX0;
    coff_plan[k0 + 1 + DELAY] = 255; fixed_exp[k0 + 1 + LAT] = FX1;
    coff_plan[k0 + 2 + DELAY] = 255; fixed_exp[k0 + 2 + LAT] = FX2;
    coff_plan[k0 + 3 + DELAY] = 0;   fixed_exp[k0 + 3 + LAT] = FX3;
    step(1, 1, 1000);
    step(0, 1, -1000);
    step(0, 1, 32767);
    step(0, 1, -32768);
    for (int i = 0; i < LINE_LEN - 4; i++) step(0, 1, rnd_din());
    step(0, 1, rnd_din());
    for (int i = 0; i < LAT + 4; i++) step(0, $urandom_range(0, 1) == 1, rnd_din());

    // Gapped input 1,0,0,1 then random gaps until the line is full.
    step(1, 1, rnd_din());
    step(0, 0, rnd_din());
    step(0, 0, rnd_din());
    step(0, 1, rnd_din());
    for (int i = 0; i < 200 && acc_cnt < LINE_LEN; i++) step(0, $urandom_range(0, 1) == 1, rnd_din());
    chk("gapped_line_filled", acc_cnt, LINE_LEN);
    for (int i = 0; i < LAT + 4; i++) step(0, 0, rnd_din());

    // Abort after 10 samples in flight; restart with a sample on the same cycle.
    step(1, 1, rnd_din());
    for (int i = 0; i < 9; i++) step(0, 1, rnd_din());
    step(1, 1, rnd_din());
    for (int i = 0; i < LINE_LEN - 1; i++) step(0, 1, rnd_din());
    for (int i = 0; i < LAT + 4; i++) step(0, 0, rnd_din());

    // New line starting exactly on the previous line's final output.
    step(1, 1, rnd_din());
    for (int i = 0; i < LINE_LEN - 1; i++) step(0, 1, rnd_din());
    last_acc = cyc - 1;
    while (cyc < last_acc + LAT) step(0, 0, rnd_din());
    chk("restart_on_done_pending", pend.size(), 1);
    step(1, 1, rnd_din());
    for (int i = 0; i < LINE_LEN - 1; i++) step(0, 1, rnd_din());
    for (int i = 0; i < LAT + 4; i++) step(0, 0, rnd_din());

    // Random traffic with occasional restarts.
    for (int i = 0; i < 700; i++) step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0, rnd_din());
    for (int i = 0; i < LAT + 4; i++) step(0, 0, rnd_din());

    // Asynchronous reset in the middle of a line.
    step(1, 1, rnd_din());
    for (int i = 0; i < 5; i++) step(0, 1, rnd_din());
    for (int i = 0; i < LAT - 2; i++) step(0, 0, rnd_din());
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_dout_valid", dout_valid, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_line_done", line_done, 0);
    chk("mid_rst_busy", busy, 0);
    pend.delete();
    busy_m  = 1'b0;
    held    = 0;
    acc_cnt = LINE_LEN;
    line_start = 1'b0;
    din_valid  = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    cyc += 4;
    for (int i = 0; i < 4; i++) step(0, 1, rnd_din());
    step(1, 1, rnd_din());
    for (int i = 0; i < LINE_LEN - 1; i++) step(0, 1, rnd_din());
    for (int i = 0; i < LAT + 4; i++) step(0, 0, rnd_din());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
